// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: FSM states and the Op field.
package multdiv_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // An operand is treated as negative only in signed mode with its MSB set.
   function automatic logic operand_neg(input logic is_signed, input logic msb);
      return is_signed & msb;
   endfunction

endpackage

// File: rtl/multdiv_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module multdiv_abs #(
   parameter int W = 32
) (
   input  logic         neg_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up (Hi/Lo result registers).
// Optional MULTDIV_EARLY_EXIT_EN: multiply stops once the remaining multiplier bits are zero.
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Op,
   input  logic             Signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t             state_q;
   logic               op_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;
   logic               divzero_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   logic [2*WIDTH-1:0] prod_d;
   logic [2*WIDTH-1:0] mcand_d;
   logic [WIDTH-1:0]   mplier_d;
   logic               mult_last;

   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_sub;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quo_d;

   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quo_fixed;
   logic [WIDTH-1:0]   rem_fixed;

   assign a_neg = operand_neg(Signed, A[WIDTH-1]);
   assign b_neg = operand_neg(Signed, B[WIDTH-1]);

   multdiv_abs #(.W(WIDTH)) u_abs_a (
      .neg_i (a_neg),
      .val_i (A),
      .val_o (abs_a)
   );

   multdiv_abs #(.W(WIDTH)) u_abs_b (
      .neg_i (b_neg),
      .val_i (B),
      .val_o (abs_b)
   );

   // Multiply step: the multiplicand walks left, so the product never needs a final realignment.
   always_comb begin
      prod_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
   end

`ifdef MULTDIV_EARLY_EXIT_EN
   assign mult_last = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
   assign mult_last = (cnt_q == LAST_CNT);
`endif

   // Divide step: remainder lives in acc_q, dividend bits shift out of mplier_q as quotient bits shift in.
   always_comb begin
      rem_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
      div_ge    = rem_shift >= {1'b0, mcand_q[WIDTH-1:0]};
      rem_sub   = rem_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0];
      rem_d     = div_ge ? rem_sub : rem_shift[WIDTH-1:0];
      quo_d     = {mplier_q[WIDTH-2:0], div_ge};
   end

   multdiv_abs #(.W(2*WIDTH)) u_fix_prod (
      .neg_i (neg_res_q),
      .val_i (acc_q),
      .val_o (prod_fixed)
   );

   multdiv_abs #(.W(WIDTH)) u_fix_quo (
      .neg_i (neg_res_q),
      .val_i (mplier_q),
      .val_o (quo_fixed)
   );

   multdiv_abs #(.W(WIDTH)) u_fix_rem (
      .neg_i (neg_rem_q),
      .val_i (acc_q[WIDTH-1:0]),
      .val_o (rem_fixed)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         op_q      <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  op_q      <= Op;
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  if ((Op == OP_DIV) && (B == '0)) begin
                     done_q    <= 1'b1;
                     divzero_q <= 1'b1;
                     state_q   <= S_DONE;
                  end else if (Op == OP_MULT) begin
                     mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                     mplier_q <= abs_b;
                     state_q  <= S_MULT;
                  end else begin
                     mcand_q  <= {{WIDTH{1'b0}}, abs_b};
                     mplier_q <= abs_a;
                     state_q  <= S_DIV;
                  end
               end
            end
            S_MULT: begin
               acc_q    <= prod_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + CW'(1);
               if (mult_last) begin
                  state_q <= S_FIX;
               end
            end
            S_DIV: begin
               acc_q    <= {{WIDTH{1'b0}}, rem_d};
               mplier_q <= quo_d;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               if (op_q == OP_MULT) begin
                  hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fixed[WIDTH-1:0];
               end else begin
                  hi_q <= rem_fixed;
                  lo_q <= quo_fixed;
               end
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q    <= 1'b0;
               divzero_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = divzero_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule
